// File: rtl/button_event_gen_if.sv
// Signal bundle between a debounced button and its event generator.
// The master drives the button level and repeat enable; the slave returns events and hold status.
`timescale 1ns/1ps

interface button_event_gen_if;
    logic DataIn;
    logic RepeatEn;
    logic Press;
    logic Release;
    logic LongPress;
    logic Repeat;
    logic Held;
    logic LongHeld;

    modport master (
        output DataIn, RepeatEn,
        input  Press, Release, LongPress, Repeat, Held, LongHeld
    );

    modport slave (
        input  DataIn, RepeatEn,
        output Press, Release, LongPress, Repeat, Held, LongHeld
    );
endinterface

// File: rtl/button_event_gen.sv
// Turns a debounced button level into registered single-cycle Press/Release/LongPress/Repeat
// events, plus Held/LongHeld status levels.
`timescale 1ns/1ps

module button_event_gen #(
    parameter int HOLD_CYCLES   = 4096,
    parameter int REPEAT_CYCLES = 1024,
    parameter int CNT_W         = 13
) (
    input logic               Clock,
    input logic               Reset,
    button_event_gen_if.slave Bus
);

    typedef enum logic [1:0] {
        Idle    = 2'b00,
        Pressed = 2'b01,
        Long    = 2'b10
    } stateT;

    localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    stateT            state, nextState;
    logic [CNT_W-1:0] cnt, nextCnt;

    logic pressQ, releaseQ, longPressQ, repeatQ, heldQ, longHeldQ;
    logic pressD, releaseD, longPressD, repeatD;

    // Next-state, next-count and next-pulse decode for the current sample.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        nextState  = state;
        nextCnt    = cnt;
        pressD     = 1'b0;
        releaseD   = 1'b0;
        longPressD = 1'b0;
        repeatD    = 1'b0;

        case (state)
            Idle: begin
                if (Bus.DataIn) begin
                    nextState = Pressed;
                    nextCnt   = CntOne;
                    pressD    = 1'b1;
                end else begin
                    nextCnt   = '0;
                end
            end

            Pressed: begin
                if (!Bus.DataIn) begin
                    nextState = Idle;
                    nextCnt   = '0;
                    releaseD  = 1'b1;
                end else if (cnt == HoldLast) begin
                    nextState  = Long;
                    nextCnt    = '0;
                    longPressD = 1'b1;
                end else begin
                    nextCnt = cnt + CntOne;
                end
            end

            Long: begin
                if (!Bus.DataIn) begin
                    nextState = Idle;
                    nextCnt   = '0;
                    releaseD  = 1'b1;
                end else if (!Bus.RepeatEn) begin
                    nextCnt = '0;
                end else if (cnt == RepeatLast) begin
                    nextCnt = '0;
                    repeatD = 1'b1;
                end else begin
                    nextCnt = cnt + CntOne;
                end
            end

            // Unreachable encoding recovers silently to idle.
            default: begin
                nextState = Idle;
                nextCnt   = '0;
            end
        endcase
    end

    // State, counter and all outputs share one register stage.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= Idle;
            cnt        <= '0;
            pressQ     <= 1'b0;
            releaseQ   <= 1'b0;
            longPressQ <= 1'b0;
            repeatQ    <= 1'b0;
            heldQ      <= 1'b0;
            longHeldQ  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state      <= nextState;
            cnt        <= nextCnt;
            pressQ     <= pressD;
            releaseQ   <= releaseD;
            longPressQ <= longPressD;
            repeatQ    <= repeatD;
            heldQ      <= (nextState != Idle);
            longHeldQ  <= (nextState == Long);
        end
    end

    assign Bus.Press     = pressQ;
    assign Bus.Release   = releaseQ;
    assign Bus.LongPress = longPressQ;
    assign Bus.Repeat    = repeatQ;
    assign Bus.Held      = heldQ;
    assign Bus.LongHeld  = longHeldQ;

endmodule

// File: tb/tb_button_event_gen.sv
// Self-checking bench for button_event_gen: directed scenarios plus random stimulus,
// every cycle compared against a run-length reference model.
`timescale 1ns/1ps

module tb_button_event_gen;

    localparam int Hold   = 4;
    localparam int Rep    = 3;
    localparam int CntW   = 3;

    logic Clock;
    logic Reset;

    button_event_gen_if bus ();

    button_event_gen #(
        .HOLD_CYCLES  (Hold),
        .REPEAT_CYCLES(Rep),
        .CNT_W        (CntW)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Bus  (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: length of the current high run and of the enabled run while long.
    int runLen = 0;
    int enRun  = 0;
    logic expPress, expRelease, expLongPress, expRepeat, expHeld, expLongHeld;

    // Observed pulse tallies per scenario.
    int seenPress, seenRelease, seenLong, seenRepeat;

    task automatic check(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) passCount++;
        else $display("FAIL %s: got %0d, wanted %0d at %0t", tag, observed, expected, $time);
    endtask

    task automatic modelClear();
        runLen = 0;
        enRun  = 0;
        {expPress, expRelease, expLongPress, expRepeat, expHeld, expLongHeld} = '0;
    endtask

    task automatic modelStep(input logic din, input logic ren);
        {expPress, expRelease, expLongPress, expRepeat} = '0;
        if (!din) begin
            if (runLen > 0) expRelease = 1'b1;
            runLen = 0;
            enRun  = 0;
        end else begin
            runLen++;
            if (runLen == 1) expPress = 1'b1;
            else if (runLen == Hold) begin
                expLongPress = 1'b1;
                enRun        = 0;
            end else if (runLen > Hold) begin
                if (ren) begin
                    enRun++;
                    if (enRun % Rep == 0) expRepeat = 1'b1;
                end else enRun = 0;
            end
        end
        expHeld     = (runLen > 0);
        expLongHeld = (runLen >= Hold);
    endtask

    task automatic compareAll();
        check("press",     int'(bus.Press),     int'(expPress));
        check("release",   int'(bus.Release),   int'(expRelease));
        check("longpress", int'(bus.LongPress), int'(expLongPress));
        check("repeat",    int'(bus.Repeat),    int'(expRepeat));
        check("held",      int'(bus.Held),      int'(expHeld));
        check("longheld",  int'(bus.LongHeld),  int'(expLongHeld));
        check("exclusive", int'((int'(bus.Press) + int'(bus.Release) +
                                 int'(bus.LongPress) + int'(bus.Repeat)) <= 1), 1);
        seenPress   += int'(bus.Press);
        seenRelease += int'(bus.Release);
        seenLong    += int'(bus.LongPress);
        seenRepeat  += int'(bus.Repeat);
    endtask

    task automatic clearTally();
        seenPress = 0; seenRelease = 0; seenLong = 0; seenRepeat = 0;
    endtask

    // Inputs are applied 1ns after an edge, outputs sampled 1ns after the next edge.
    task automatic doCycle(input logic din, input logic ren);
        bus.DataIn   = din;
        bus.RepeatEn = ren;
        @(posedge Clock);
        if (Reset) modelStep(din, ren);
        else       modelClear();
        #1;
        compareAll();
    endtask

    task automatic assertReset();
        Reset = 1'b0;
        modelClear();
        #1;
        compareAll();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset        = 1'b0;
        bus.DataIn   = 1'b0;
        bus.RepeatEn = 1'b1;
        modelClear();
        clearTally();

        // 1: reset held with toggling input, then release with input high.
        #2;
        compareAll();
        for (int i = 0; i < 4; i++) doCycle(logic'(i % 2 == 0), 1'b1);
        check("s1_reset_quiet", seenPress + seenRelease + seenLong + seenRepeat, 0);
        #2 Reset = 1'b1;
        clearTally();
        doCycle(1'b1, 1'b1);
        check("s1_press", int'(bus.Press), 1);
        check("s1_held",  int'(bus.Held),  1);
        doCycle(1'b0, 1'b1);
        doCycle(1'b0, 1'b1);

        // 2: two-edge press.
        clearTally();
        doCycle(1'b1, 1'b1);
        doCycle(1'b1, 1'b1);
        doCycle(1'b0, 1'b1);
        check("s2_release", int'(bus.Release), 1);
        check("s2_nolong",  seenLong, 0);
        doCycle(1'b0, 1'b1);

        // 3: long hold with repeats at e6, e9, e12; release at e13.
        clearTally();
        for (int e = 0; e <= 12; e++) begin
            doCycle(1'b1, 1'b1);
            if (e == 3) check("s3_longheld", int'(bus.LongHeld), 1);
        end
        doCycle(1'b0, 1'b1);
        check("s3_repeats", seenRepeat, 3);
        check("s3_long",    seenLong,   1);
        check("s3_idle",    int'(bus.Held) + int'(bus.LongHeld), 0);
        doCycle(1'b0, 1'b1);

        // 4: repeat disabled over e5..e10, next repeat lands on e13.
        clearTally();
        for (int e = 0; e <= 13; e++) begin
            doCycle(1'b1, logic'(!(e >= 5 && e <= 10)));
            if (e == 10) check("s4_gap", seenRepeat, 0);
        end
        check("s4_e13_repeat", int'(bus.Repeat), 1);
        doCycle(1'b0, 1'b1);
        doCycle(1'b0, 1'b1);

        // 5: release on the threshold edge wins.
        clearTally();
        for (int e = 0; e <= 2; e++) doCycle(1'b1, 1'b1);
        doCycle(1'b0, 1'b1);
        check("s5_release", int'(bus.Release), 1);
        check("s5_nolong",  seenLong, 0);
        check("s5_idle",    int'(bus.Held), 0);

        // 6: reset during a long hold, restart with input high.
        for (int e = 0; e <= 6; e++) doCycle(1'b1, 1'b1);
        clearTally();
        assertReset();
        doCycle(1'b1, 1'b1);
        doCycle(1'b1, 1'b1);
        #2 Reset = 1'b1;
        doCycle(1'b1, 1'b1);
        check("s6_norelease", seenRelease, 0);
        check("s6_press",     int'(bus.Press), 1);
        for (int e = 1; e <= 3; e++) doCycle(1'b1, 1'b1);
        check("s6_long", int'(bus.LongPress), 1);
        doCycle(1'b0, 1'b1);

        // Random traffic: sticky button level, mostly enabled repeat, rare resets.
        for (int i = 0; i < 600; i++) begin
            logic din, ren;
            din = ($urandom_range(0, 7) == 0) ? ~bus.DataIn : bus.DataIn;
            ren = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 199) == 0) begin
                assertReset();
                doCycle(din, ren);
                #2 Reset = 1'b1;
            end else begin
                doCycle(din, ren);
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
